// File: rtl/ram_burst_control_pkg.sv
// ---------------------------------------------------------------------------
// ram_burst_control_pkg
// Shared types and default sizes for the cache-line <-> narrow block RAM
// burst controller.
//   ram_burst_state_t : controller FSM states
//   RAM_WORD_WIDTH    : default cache word width
//   RAM_HALF_WIDTH    : default block RAM data width
//   CACHE_LINE_WORDS  : default words per cache line
//   MAIN_RAM_DEPTH    : default RAM entries
//   burst_beats()     : number of RAM beats needed to move one line
// ---------------------------------------------------------------------------
package ram_burst_control_pkg;

  localparam int RAM_WORD_WIDTH   = 32;
  localparam int RAM_HALF_WIDTH   = 16;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int MAIN_RAM_DEPTH   = 4096;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } ram_burst_state_t;

  function automatic int burst_beats(input int line_words, input int word_width,
                                     input int ram_width);
    return line_words * (word_width / ram_width);
  endfunction

endpackage

// File: rtl/ram_burst_control_addr_wrap_counter.sv
// ---------------------------------------------------------------------------
// ram_addr_wrap_counter
// Loadable RAM address counter that wraps modulo RAM_DEPTH. Wrap is done by
// compare-and-clear, so RAM_DEPTH does not have to be a power of two.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset (counter -> 0)
//   load       : load load_addr as the current address
//   load_addr  : address loaded on load
//   inc        : advance to the next address (ignored when load is high)
//   next_addr  : address that follows the current one, already wrapped
// ---------------------------------------------------------------------------
module ram_addr_wrap_counter #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] addr_reg;

  assign next_addr = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
    end else if (load) begin
      addr_reg <= load_addr;
    end else if (inc) begin
      addr_reg <= next_addr;
    end
  end

endmodule

// File: rtl/ram_burst_control.sv
// ---------------------------------------------------------------------------
// ram_burst_control
// Moves a cache line of LINE_WORDS x WORD_WIDTH bits to/from a synchronous
// block RAM RAM_WIDTH bits wide, one RAM beat per cycle. Beat k carries line
// bits [k*RAM_WIDTH +: RAM_WIDTH] at address (base + k) mod RAM_DEPTH.
// Writes win over reads when both are requested in IDLE.
// Ports:
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   wr_start        : writeback request (level, sampled in IDLE only)
//   rd_start        : line-fill request (level, sampled in IDLE only)
//   wr_addr_base    : first RAM address of the write (latched on accept)
//   rd_addr_base    : first RAM address of the read (latched on accept)
//   wr_line_in      : line to write, word 0 in the LSBs (latched on accept)
//   rd_line_out     : last completed read line, held until the next read
//   wr_done/rd_done : one-cycle completion pulses
//   busy            : burst in progress
//   ram_wr_en/ram_wr_addr/ram_wr_data : RAM write port
//   ram_rd_addr/ram_rd_data           : RAM read port, RD_LATENCY cycles
// ---------------------------------------------------------------------------
module ram_burst_control
  import ram_burst_control_pkg::*;
#(
  parameter int WORD_WIDTH = RAM_WORD_WIDTH,
  parameter int RAM_WIDTH  = RAM_HALF_WIDTH,
  parameter int LINE_WORDS = CACHE_LINE_WORDS,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = MAIN_RAM_DEPTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_start,
  input  logic                             rd_start,
  input  logic [ADDR_WIDTH-1:0]            wr_addr_base,
  input  logic [ADDR_WIDTH-1:0]            rd_addr_base,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] wr_line_in,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] rd_line_out,
  output logic                             wr_done,
  output logic                             rd_done,
  output logic                             busy,
  output logic                             ram_wr_en,
  output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
  output logic [RAM_WIDTH-1:0]             ram_wr_data,
  output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]             ram_rd_data
);

  localparam int N_BEATS    = burst_beats(LINE_WORDS, WORD_WIDTH, RAM_WIDTH);
  localparam int LINE_BITS  = LINE_WORDS * WORD_WIDTH;
  localparam int BEAT_CNT_W = $clog2(N_BEATS + 1);
  localparam int LAT_CNT_W  = $clog2(RD_LATENCY + 1);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(N_BEATS - 1);
  localparam logic [LAT_CNT_W-1:0]  LAST_LAT  = LAT_CNT_W'(RD_LATENCY - 1);

  // Parameter sanity checks, evaluated at elaboration.
  if (WORD_WIDTH % RAM_WIDTH != 0) begin : g_chk_word_width
    $error("ram_burst_control: WORD_WIDTH must be a multiple of RAM_WIDTH");
  end
  if (longint'(RAM_DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_depth
    $error("ram_burst_control: RAM_DEPTH does not fit in ADDR_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_latency
    $error("ram_burst_control: RD_LATENCY must be 1..4");
  end
  if (N_BEATS < 2) begin : g_chk_beats
    $error("ram_burst_control: a burst needs at least two RAM beats");
  end

  ram_burst_state_t              state_reg;
  logic [BEAT_CNT_W-1:0]         beat_cnt_reg;
  logic [LAT_CNT_W-1:0]          lat_cnt_reg;
  logic [LINE_BITS-1:0]          wr_shift_reg;
  // Holds the N-1 most recent read beats; the newest beat enters at the top
  // so that after N captures beat 0 sits in the LSBs.
  logic [LINE_BITS-RAM_WIDTH-1:0] rd_shift_reg;
  logic [LINE_BITS-1:0]          rd_shift_next;
  // rd_pipe_reg[i] set means an address was presented i+1 cycles ago.
  logic [RD_LATENCY-1:0]         rd_pipe_reg;
  logic                          capture;

  logic                          addr_load;
  logic                          addr_inc;
  logic [ADDR_WIDTH-1:0]         addr_load_value;
  logic [ADDR_WIDTH-1:0]         addr_next;

  // -------------------------------------------------------------------------
  // Shared address counter: loaded with the accepted base in IDLE and
  // stepped once per beat in WRITE/READ. Its wrapped successor feeds whichever
  // RAM port is active; the ports themselves keep their last value when idle.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_load       = 1'b0;
    addr_inc        = 1'b0;
    addr_load_value = rd_addr_base;
    case (state_reg)
      IDLE: begin
        addr_load       = wr_start | rd_start;
        addr_load_value = wr_start ? wr_addr_base : rd_addr_base;
      end
      WRITE, READ: begin
        addr_inc = (beat_cnt_reg != LAST_BEAT);
      end
      default: begin
      end
    endcase
  end

  ram_addr_wrap_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (addr_load),
    .load_addr (addr_load_value),
    .inc       (addr_inc),
    .next_addr (addr_next)
  );

  // -------------------------------------------------------------------------
  // Read-data alignment: a beat's data is valid RD_LATENCY cycles after its
  // address was on ram_rd_addr, so the READ flag is delayed by that much.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else begin
          rd_pipe_reg[gi] <= (state_reg == READ);
        end
      end
    end else begin : g_rest
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_pipe_reg[gi] <= 1'b0;
        end else begin
          rd_pipe_reg[gi] <= rd_pipe_reg[gi-1];
        end
      end
    end
  end

  assign capture       = rd_pipe_reg[RD_LATENCY-1];
  assign rd_shift_next = {ram_rd_data, rd_shift_reg};

  // -------------------------------------------------------------------------
  // Burst FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      lat_cnt_reg  <= '0;
      wr_shift_reg <= '0;
      rd_shift_reg <= '0;
      rd_line_out  <= '0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      busy         <= 1'b0;
      ram_wr_en    <= 1'b0;
      ram_wr_addr  <= '0;
      ram_wr_data  <= '0;
      ram_rd_addr  <= '0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;

      if (capture) begin
        rd_shift_reg <= rd_shift_next[LINE_BITS-1:RAM_WIDTH];
      end

      case (state_reg)
        IDLE: begin
          if (wr_start) begin
            // Beat 0 goes out straight from the input; the rest of the line
            // is kept in a shift register so later input changes are ignored.
            state_reg    <= WRITE;
            busy         <= 1'b1;
            beat_cnt_reg <= '0;
            ram_wr_en    <= 1'b1;
            ram_wr_addr  <= wr_addr_base;
            ram_wr_data  <= wr_line_in[RAM_WIDTH-1:0];
            wr_shift_reg <= wr_line_in >> RAM_WIDTH;
          end else if (rd_start) begin
            state_reg    <= READ;
            busy         <= 1'b1;
            beat_cnt_reg <= '0;
            ram_rd_addr  <= rd_addr_base;
          end
        end

        WRITE: begin
          if (beat_cnt_reg == LAST_BEAT) begin
            state_reg <= DONE;
            ram_wr_en <= 1'b0;
            busy      <= 1'b0;
            wr_done   <= 1'b1;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
            ram_wr_addr  <= addr_next;
            ram_wr_data  <= wr_shift_reg[RAM_WIDTH-1:0];
            wr_shift_reg <= wr_shift_reg >> RAM_WIDTH;
          end
        end

        READ: begin
          if (beat_cnt_reg == LAST_BEAT) begin
            state_reg   <= DRAIN;
            lat_cnt_reg <= '0;
          end else begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
            ram_rd_addr  <= addr_next;
          end
        end

        DRAIN: begin
          // The last beat is captured on the same edge that leaves DRAIN, so
          // the completed line is taken from the shift input, not the register.
          if (lat_cnt_reg == LAST_LAT) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            rd_done     <= 1'b1;
            rd_line_out <= rd_shift_next;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_CNT_W'(1);
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Base addresses must already be inside the RAM; only the increment wraps.
  always @(posedge clk) begin
    if (!reset && state_reg == IDLE) begin
      if (wr_start) begin
        assert (longint'(wr_addr_base) < longint'(RAM_DEPTH))
          else $error("ram_burst_control: wr_addr_base %0d >= RAM_DEPTH", wr_addr_base);
      end else if (rd_start) begin
        assert (longint'(rd_addr_base) < longint'(RAM_DEPTH))
          else $error("ram_burst_control: rd_addr_base %0d >= RAM_DEPTH", rd_addr_base);
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_control.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_control
// Two controller instances: A with default parameters (N=8, latency 1) and
// B with WORD_WIDTH=64, LINE_WORDS=2, RD_LATENCY=3 (N=8). Each drives its own
// behavioural RAM. A reference memory per instance tracks what the RAM should
// contain; expected beats are (base+k) mod DEPTH / line[16k +: 16].
// ---------------------------------------------------------------------------
module tb_ram_burst_control;

  localparam int DEPTH = 4096;
  localparam int NA    = 8;
  localparam int LA    = 1;
  localparam int NB    = 8;
  localparam int LB    = 3;
  localparam logic [127:0] PLAN_LINE = {32'h44556677, 32'h00000000, 32'h11223344, 32'hAABBCCDD};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A signals
  logic         rst_a, wr_start_a, rd_start_a;
  logic [31:0]  wr_base_a, rd_base_a;
  logic [127:0] wr_line_a, rd_line_a;
  logic         wr_done_a, rd_done_a, busy_a, ram_wr_en_a;
  logic [31:0]  ram_wr_addr_a, ram_rd_addr_a;
  logic [15:0]  ram_wr_data_a, ram_rd_data_a;

  // Instance B signals
  logic         rst_b, wr_start_b, rd_start_b;
  logic [31:0]  wr_base_b, rd_base_b;
  logic [127:0] wr_line_b, rd_line_b;
  logic         wr_done_b, rd_done_b, busy_b, ram_wr_en_b;
  logic [31:0]  ram_wr_addr_b, ram_rd_addr_b;
  logic [15:0]  ram_wr_data_b, ram_rd_data_b;

  ram_burst_control dut_a (
    .clk(clk), .reset(rst_a), .wr_start(wr_start_a), .rd_start(rd_start_a),
    .wr_addr_base(wr_base_a), .rd_addr_base(rd_base_a), .wr_line_in(wr_line_a),
    .rd_line_out(rd_line_a), .wr_done(wr_done_a), .rd_done(rd_done_a), .busy(busy_a),
    .ram_wr_en(ram_wr_en_a), .ram_wr_addr(ram_wr_addr_a), .ram_wr_data(ram_wr_data_a),
    .ram_rd_addr(ram_rd_addr_a), .ram_rd_data(ram_rd_data_a)
  );

  ram_burst_control #(.WORD_WIDTH(64), .LINE_WORDS(2), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b), .wr_start(wr_start_b), .rd_start(rd_start_b),
    .wr_addr_base(wr_base_b), .rd_addr_base(rd_base_b), .wr_line_in(wr_line_b),
    .rd_line_out(rd_line_b), .wr_done(wr_done_b), .rd_done(rd_done_b), .busy(busy_b),
    .ram_wr_en(ram_wr_en_b), .ram_wr_addr(ram_wr_addr_b), .ram_wr_data(ram_wr_data_b),
    .ram_rd_addr(ram_rd_addr_b), .ram_rd_data(ram_rd_data_b)
  );

  // Behavioural RAMs with a backdoor preload port.
  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];
  logic [15:0] ref_a [DEPTH];
  logic [15:0] ref_b [DEPTH];
  logic        bd_we = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [15:0] bd_data_a = '0, bd_data_b = '0;
  logic [15:0] rq_a, rq_b1, rq_b2, rq_b3;

  always @(posedge clk) begin
    if (bd_we) begin
      mem_a[bd_addr] <= bd_data_a;
      mem_b[bd_addr] <= bd_data_b;
    end
    if (ram_wr_en_a) mem_a[ram_wr_addr_a[11:0]] <= ram_wr_data_a;
    if (ram_wr_en_b) mem_b[ram_wr_addr_b[11:0]] <= ram_wr_data_b;
    rq_a  <= mem_a[ram_rd_addr_a[11:0]];
    rq_b1 <= mem_b[ram_rd_addr_b[11:0]];
    rq_b2 <= rq_b1;
    rq_b3 <= rq_b2;
  end

  assign ram_rd_data_a = rq_a;
  assign ram_rd_data_b = rq_b3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2000000");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  task automatic do_write_a(input logic [31:0] base, input logic [127:0] line, input bit poke);
    logic [31:0] ea;
    logic [15:0] ed;
    @(negedge clk);
    wr_base_a = base; wr_line_a = line; wr_start_a = 1'b1;
    @(negedge clk);  // cycle 1
    wr_start_a = 1'b0;
    wr_base_a  = $urandom_range(0, DEPTH - 1);
    wr_line_a  = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < NA; k++) begin
      if (k > 0) @(negedge clk);
      if (poke) rd_start_a = (k > 0 && k < NA - 1);
      ea = (base + 32'(k)) % DEPTH;
      ed = line[k*16 +: 16];
      checks++;
      if (ram_wr_en_a !== 1'b1 || ram_wr_addr_a !== ea || ram_wr_data_a !== ed ||
          busy_a !== 1'b1 || wr_done_a !== 1'b0) begin
        errors++;
        $display("FAIL write_beat%0d: got en=%b addr=%0d data=%h busy=%b done=%b, want en=1 addr=%0d data=%h busy=1 done=0",
                 k, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, busy_a, wr_done_a, ea, ed);
      end
      ref_a[ea[11:0]] = ed;
    end
    rd_start_a = 1'b0;
    @(negedge clk);  // cycle N+1
    checks++;
    if (wr_done_a !== 1'b1 || busy_a !== 1'b0 || ram_wr_en_a !== 1'b0 || rd_done_a !== 1'b0) begin
      errors++;
      $display("FAIL write_done: got done=%b busy=%b en=%b rd_done=%b, want 1 0 0 0",
               wr_done_a, busy_a, ram_wr_en_a, rd_done_a);
    end
    $display("write A base=%0d line=%h poke=%0d", base, line, poke);
  endtask

  task automatic do_read_a(input logic [31:0] base);
    logic [127:0] exp_line;
    logic [31:0]  ea;
    for (int k = 0; k < NA; k++) exp_line[k*16 +: 16] = ref_a[(base + 32'(k)) % DEPTH];
    @(negedge clk);
    rd_base_a = base; rd_start_a = 1'b1;
    @(negedge clk);  // cycle 1
    rd_start_a = 1'b0;
    rd_base_a  = $urandom_range(0, DEPTH - 1);
    for (int k = 0; k < NA; k++) begin
      if (k > 0) @(negedge clk);
      ea = (base + 32'(k)) % DEPTH;
      checks++;
      if (ram_rd_addr_a !== ea || busy_a !== 1'b1 || ram_wr_en_a !== 1'b0 || rd_done_a !== 1'b0) begin
        errors++;
        $display("FAIL read_addr%0d: got addr=%0d busy=%b wr_en=%b rd_done=%b, want addr=%0d busy=1 wr_en=0 rd_done=0",
                 k, ram_rd_addr_a, busy_a, ram_wr_en_a, rd_done_a, ea);
      end
    end
    for (int d = 0; d < LA; d++) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || rd_done_a !== 1'b0) begin
        errors++;
        $display("FAIL read_drain%0d: got busy=%b rd_done=%b, want 1 0", d, busy_a, rd_done_a);
      end
    end
    @(negedge clk);  // cycle N+L+1
    checks++;
    if (rd_done_a !== 1'b1 || busy_a !== 1'b0 || rd_line_a !== exp_line) begin
      errors++;
      $display("FAIL read_done: got rd_done=%b busy=%b line=%h, want 1 0 %h",
               rd_done_a, busy_a, rd_line_a, exp_line);
    end
    $display("read A base=%0d line=%h", base, rd_line_a);
  endtask

  task automatic do_read_b(input logic [31:0] base);
    logic [127:0] exp_line;
    logic [31:0]  ea;
    for (int k = 0; k < NB; k++) exp_line[k*16 +: 16] = ref_b[(base + 32'(k)) % DEPTH];
    @(negedge clk);
    rd_base_b = base; rd_start_b = 1'b1;
    @(negedge clk);  // cycle 1
    rd_start_b = 1'b0;
    rd_base_b  = $urandom_range(0, DEPTH - 1);
    for (int c = 1; c <= NB + LB; c++) begin
      if (c > 1) @(negedge clk);
      ea = (base + 32'(c - 1)) % DEPTH;
      checks++;
      if (busy_b !== 1'b1 || rd_done_b !== 1'b0 || ram_wr_en_b !== 1'b0 ||
          (c <= NB && ram_rd_addr_b !== ea)) begin
        errors++;
        $display("FAIL b_read_cycle%0d: got addr=%0d busy=%b rd_done=%b wr_en=%b, want addr=%0d busy=1 rd_done=0 wr_en=0",
                 c, ram_rd_addr_b, busy_b, rd_done_b, ram_wr_en_b, ea);
      end
    end
    @(negedge clk);  // cycle 12
    checks++;
    if (rd_done_b !== 1'b1 || busy_b !== 1'b0 || rd_line_b !== exp_line) begin
      errors++;
      $display("FAIL b_read_done: got rd_done=%b busy=%b line=%h, want 1 0 %h",
               rd_done_b, busy_b, rd_line_b, exp_line);
    end
    $display("read B base=%0d line=%h", base, rd_line_b);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    wr_start_a = 0; rd_start_a = 0; wr_base_a = 0; rd_base_a = 0; wr_line_a = 0;
    wr_start_b = 0; rd_start_b = 0; wr_base_b = 0; rd_base_b = 0; wr_line_b = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_line_a, wr_done_a, rd_done_a, busy_a, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, ram_rd_addr_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: got line=%h wd=%b rd=%b busy=%b en=%b wa=%h wd=%h ra=%h, want all 0",
               rd_line_a, wr_done_a, rd_done_a, busy_a, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, ram_rd_addr_a);
    end
    checks++;
    if ({rd_line_b, wr_done_b, rd_done_b, busy_b, ram_wr_en_b, ram_wr_addr_b, ram_wr_data_b, ram_rd_addr_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: got line=%h busy=%b en=%b ra=%h, want all 0", rd_line_b, busy_b, ram_wr_en_b, ram_rd_addr_b);
    end
    // Preload both RAMs (and the reference copies) while held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 12'(i);
      bd_data_a = 16'($urandom); bd_data_b = 16'($urandom);
      ref_a[i] = bd_data_a; ref_b[i] = bd_data_b;
    end
    @(negedge clk);
    bd_we = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || ram_wr_en_a !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy_a=%b busy_b=%b en=%b, want 0 0 0", busy_a, busy_b, ram_wr_en_a);
    end
    $display("reset released");
  endtask

  task automatic test_write_boundary();
    do_write_a(32'd4086, PLAN_LINE, 1'b0);
  endtask

  task automatic test_read_after_write();
    do_read_a(32'd4086);
    checks++;
    if (rd_line_a !== PLAN_LINE) begin
      errors++;
      $display("FAIL read_plan_line: got %h, want %h", rd_line_a, PLAN_LINE);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] line;
    logic [127:0] held;
    line = {$urandom, $urandom, $urandom, $urandom};
    do_write_a(32'd4092, line, 1'b0);
    do_read_a(32'd4092);
    checks++;
    if (rd_line_a !== line) begin
      errors++;
      $display("FAIL wrap_readback: got %h, want %h", rd_line_a, line);
    end
    held = line;
    do_write_a(32'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    checks++;
    if (rd_line_a !== held) begin
      errors++;
      $display("FAIL rd_line_hold: got %h, want %h", rd_line_a, held);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write_a(32'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom},
                   1'($urandom_range(0, 1)));
      else
        do_read_a(32'($urandom_range(0, DEPTH - 1)));
    end
  endtask

  task automatic test_arbitration();
    logic [127:0] line, exp_line;
    logic [31:0]  ea;
    line = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_base_a = 32'd55; rd_base_a = 32'd4086; wr_line_a = line;
    wr_start_a = 1'b1; rd_start_a = 1'b1;
    @(negedge clk);  // cycle 1
    wr_start_a = 1'b0;
    for (int k = 0; k < NA; k++) begin
      if (k > 0) @(negedge clk);
      ea = 32'd55 + 32'(k);
      checks++;
      if (ram_wr_en_a !== 1'b1 || ram_wr_addr_a !== ea || ram_wr_data_a !== line[k*16 +: 16]) begin
        errors++;
        $display("FAIL arb_write%0d: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                 k, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, ea, line[k*16 +: 16]);
      end
      ref_a[ea[11:0]] = line[k*16 +: 16];
    end
    for (int k = 0; k < NA; k++) exp_line[k*16 +: 16] = ref_a[(32'd4086 + 32'(k)) % DEPTH];
    @(negedge clk);  // cycle 9: DONE
    checks++;
    if (wr_done_a !== 1'b1 || rd_done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL arb_wr_done: got wr_done=%b rd_done=%b busy=%b, want 1 0 0", wr_done_a, rd_done_a, busy_a);
    end
    @(negedge clk);  // cycle 10: IDLE
    checks++;
    if (busy_a !== 1'b0 || wr_done_a !== 1'b0 || ram_wr_en_a !== 1'b0) begin
      errors++;
      $display("FAIL arb_idle_gap: got busy=%b wr_done=%b en=%b, want 0 0 0", busy_a, wr_done_a, ram_wr_en_a);
    end
    for (int c = 11; c <= 19; c++) begin
      @(negedge clk);
      if (c == 11) rd_start_a = 1'b0;
      ea = (32'd4086 + 32'(c - 11)) % DEPTH;
      checks++;
      if (busy_a !== 1'b1 || rd_done_a !== 1'b0 || (c <= 18 && ram_rd_addr_a !== ea)) begin
        errors++;
        $display("FAIL arb_read_cycle%0d: got addr=%0d busy=%b rd_done=%b, want addr=%0d busy=1 rd_done=0",
                 c, ram_rd_addr_a, busy_a, rd_done_a, ea);
      end
    end
    @(negedge clk);  // cycle 20
    checks++;
    if (rd_done_a !== 1'b1 || rd_line_a !== exp_line) begin
      errors++;
      $display("FAIL arb_rd_done: got rd_done=%b line=%h, want 1 %h", rd_done_a, rd_line_a, exp_line);
    end
    $display("arbitration A wr base=55 then rd base=4086 line=%h", rd_line_a);
  endtask

  task automatic test_back_to_back();
    logic [31:0] b0;
    b0 = 32'($urandom_range(0, DEPTH - 1));
    do_write_a(b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    do_write_a(32'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    do_read_a(b0);
    do_read_a(32'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic test_latency3();
    do_read_b(32'($urandom_range(0, DEPTH - 1)));
    do_read_b(32'd4090);
    do_read_b(32'd0);
    checks++;
    if (wr_done_b !== 1'b0 || ram_wr_addr_b !== 32'd0 || ram_wr_data_b !== 16'd0) begin
      errors++;
      $display("FAIL b_write_idle: got wr_done=%b waddr=%0d wdata=%h, want 0 0 0", wr_done_b, ram_wr_addr_b, ram_wr_data_b);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] line;
    logic [31:0]  base;
    bit           saw_done;
    base = 32'd1000;
    line = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_base_a = base; wr_line_a = line; wr_start_a = 1'b1;
    @(negedge clk);  // cycle 1
    wr_start_a = 1'b0;
    ref_a[base[11:0]] = line[15:0];
    @(negedge clk);  // cycle 2
    ref_a[base[11:0] + 12'd1] = line[31:16];
    @(negedge clk);  // cycle 3
    rst_a = 1'b1;
    #1;
    checks++;
    if ({rd_line_a, wr_done_a, rd_done_a, busy_a, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, ram_rd_addr_a} !== '0) begin
      errors++;
      $display("FAIL async_reset: got line=%h busy=%b en=%b wa=%h wd=%h ra=%h, want all 0",
               rd_line_a, busy_a, ram_wr_en_a, ram_wr_addr_a, ram_wr_data_a, ram_rd_addr_a);
    end
    @(negedge clk);
    rst_a = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < NA + 2; c++) begin
      @(negedge clk);
      if (wr_done_a === 1'b1 || busy_a !== 1'b0 || ram_wr_en_a !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: got activity after aborted write, want none");
    end
    $display("reset mid-write A base=%0d aborted", base);
    do_write_a(base, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    do_read_a(base);
  endtask

  initial begin
    test_reset();
    test_write_boundary();
    test_read_after_write();
    test_wrap();
    test_random();
    test_arbitration();
    test_back_to_back();
    test_latency3();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_control.md
Name: ram_burst_control

Overview:
- Parametrised successor to the word-to-halfword RAM controller.
- Moves a whole cache line of LINE_WORDS words, each WORD_WIDTH bits, between the cache controller and a narrow synchronous block RAM of width RAM_WIDTH.
- Each word is split into BEATS = WORD_WIDTH/RAM_WIDTH RAM beats.
- Adds line bursts, configurable read latency, address wrap at RAM_DEPTH, arbitration between simultaneous requests, and a busy flag.

Parameters:
- WORD_WIDTH, 32, cache-side word width; must be a multiple of RAM_WIDTH.
- RAM_WIDTH, 16, block RAM data width.
- LINE_WORDS, 4, words per burst (cache line).
- ADDR_WIDTH, 32, RAM address width.
- RAM_DEPTH, 4096, RAM entries; addresses wrap modulo RAM_DEPTH.
- RD_LATENCY, 1, cycles from ram_rd_addr to valid ram_rd_data (1..4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_start  in  1  writeback request (level).
- rd_start  in  1  line-fill request (level).
- wr_addr_base  in  ADDR_WIDTH  first RAM address of the write; must be < RAM_DEPTH.
- rd_addr_base  in  ADDR_WIDTH  first RAM address of the read; must be < RAM_DEPTH.
- wr_line_in  in  LINE_WORDS*WORD_WIDTH  line to write; word 0 in the LSBs.
- rd_line_out  out  LINE_WORDS*WORD_WIDTH  last completed read line.
- wr_done  out  1  one-cycle pulse when the write completes.
- rd_done  out  1  one-cycle pulse when rd_line_out is updated.
- busy  out  1  burst in progress.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_wr_data  out  RAM_WIDTH  RAM write data.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_data  in  RAM_WIDTH  RAM read data.

Behaviour:
- Reset:
  - state IDLE; all outputs 0, including rd_line_out.
  - A reset mid-burst aborts it: no done pulse, partially written RAM contents are left as is.
- Beat mapping:
  - N = LINE_WORDS*BEATS beats per burst.
  - Beat k carries bits [k*RAM_WIDTH +: RAM_WIDTH] of the line; little-endian, lower half at the lower address.
  - Beat k uses address (base+k) mod RAM_DEPTH; wrap is by compare-and-clear, so RAM_DEPTH need not be a power of 2.
- Request sampling:
  - Requests are sampled only in IDLE; starts while busy are ignored.
  - If both starts are high in IDLE, the write wins. A held rd_start is served after wr_done.
  - Base address and wr_line_in are latched at acceptance; later input changes have no effect.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- Write timing (start accepted at edge 0):
  - WRITE for cycles 1..N: ram_wr_en=1, address and data for beat k on cycle k+1.
  - DONE on cycle N+1: wr_done=1, busy=0; then IDLE.
  - busy=1 on cycles 1..N.
- Read timing:
  - READ for cycles 1..N: ram_rd_addr = beat address, ram_wr_en=0.
  - DRAIN for RD_LATENCY cycles.
  - Capture: data for beat k is sampled RD_LATENCY cycles after its address is presented, into a shift/index register.
  - DONE on cycle N+RD_LATENCY+1: rd_line_out updated that cycle, rd_done=1, busy=0.
  - rd_line_out holds its value until the next read completes.
- Port defaults: ram_wr_addr, ram_wr_data and ram_rd_addr hold their last value when idle; ram_wr_en=0 outside WRITE.
- Back-to-back: a new burst may be accepted on the cycle after DONE, so the minimum gap is one IDLE cycle.
- Counters: beat counter $clog2(N+1) bits; latency counter $clog2(RD_LATENCY+1) bits.
- Elaboration assertions: WORD_WIDTH % RAM_WIDTH == 0, RAM_DEPTH <= 2**ADDR_WIDTH.
- Simulation assertion: base < RAM_DEPTH.

Decomposition:
- package_project_typedefs gains:
  - ram_burst_state_t enum {IDLE, WRITE, READ, DRAIN, DONE}.
  - Default localparams RAM_WORD_WIDTH=32, RAM_HALF_WIDTH=16, CACHE_LINE_WORDS=4, MAIN_RAM_DEPTH=4096.
- One sub-module, ram_addr_wrap_counter: a loadable address counter with modulo-RAM_DEPTH increment, shared by the write and read paths.

Test Plan:
- Write base 4086, line {0x44556677, 0x0, 0x11223344, 0xAABBCCDD} (default parameters) -> ram_wr_en high 8 cycles; addresses 4086..4093; data CCDD, AABB, 3344, 1122, 0000, 0000, 6677, 4455; wr_done on cycle 9.
- Read base 4086 after that write, RD_LATENCY=1 -> ram_rd_addr 4086..4093; rd_done on cycle 10; rd_line_out equals the written line.
- Wrap: write base 4092 -> addresses 4092, 4093, 4094, 4095, 0, 1, 2, 3. A read back from 4092 returns an identical line.
- Simultaneous wr_start=rd_start=1 held, wr base 55, rd base 4086 -> write burst to 55..62 first, wr_done, one IDLE cycle, then read of 4086; rd_done follows.
- Reset asserted on cycle 3 of a write -> all outputs 0 asynchronously; no wr_done. After release, a fresh write completes normally.
- RD_LATENCY=3, LINE_WORDS=2, WORD_WIDTH=64 instance -> N=8; rd_done on cycle 12; beats assembled in order.
